// File: rtl/coco_clk_reset_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : coco_clk_reset_gen                                              |
// | Purpose  : PLL-lock to system reset sequencer plus CoCo2 timing enables    |
// |            (pixel, colorburst, 6809 E/Q) derived from the 57.27 MHz clock. |
// | Options  : LOCK_LOSS_COUNT_EN adds a saturating lock-loss counter output.  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module coco_clk_reset_gen #(
    parameter int unsigned LOCK_HOLD = 1024,
    parameter int unsigned E_DIV     = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       locked,
    output logic       sys_reset,
    output logic       ce_pix,
    output logic       ce_burst,
    output logic       cpu_e,
    output logic       cpu_q,
    output logic       cpu_e_rise,
    output logic       cpu_e_fall
`ifdef LOCK_LOSS_COUNT_EN
    ,
    output logic [7:0] lock_loss_cnt
`endif
);

    localparam int unsigned     c_ph_w      = $clog2(E_DIV);
    localparam logic [15:0]     c_hold_last = 16'(LOCK_HOLD - 1);
    localparam logic [c_ph_w-1:0] c_q_start = c_ph_w'(E_DIV / 4);
    localparam logic [c_ph_w-1:0] c_q_end   = c_ph_w'((3 * E_DIV) / 4 - 1);
    localparam logic [c_ph_w-1:0] c_e_start = c_ph_w'(E_DIV / 2);
    localparam logic [c_ph_w-1:0] c_ph_max  = c_ph_w'(E_DIV - 1);

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_HOLD      = 2'd1,
        ST_RUN       = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [15:0]         r_hold_cnt;
    logic [15:0]         w_hold_nxt;
    logic                r_sync1;
    logic                r_locked_s;
    logic [c_ph_w-1:0]   r_ph;
    logic                w_run;

    // locked comes straight from the PLL and is asynchronous to clk
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1    <= 1'b0;
            r_locked_s <= 1'b0;
        end else begin
            r_sync1    <= locked;
            r_locked_s <= r_sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_WAIT_LOCK;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold_cnt;
        case (r_state)
            ST_WAIT_LOCK: begin
                w_hold_nxt = '0;
                if (r_locked_s) begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!r_locked_s) begin
                    w_state_nxt = ST_WAIT_LOCK;
                end else if (r_hold_cnt == c_hold_last) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_hold_nxt = r_hold_cnt + 16'd1;
                end
            end
            ST_RUN: begin
                if (!r_locked_s) begin
                    w_state_nxt = ST_WAIT_LOCK;
                end
            end
            default: begin
                w_state_nxt = ST_WAIT_LOCK;
            end
        endcase
    end

    // Held at zero outside RUN so every re-entry starts a whole E period
    always_ff @(posedge clk) begin
        if (rst || (r_state != ST_RUN)) begin
            r_ph <= '0;
        end else begin
            r_ph <= r_ph + 1'b1;
        end
    end

    assign w_run      = (r_state == ST_RUN);
    assign sys_reset  = ~w_run;
    assign ce_pix     = w_run & (r_ph[1:0] == 2'b11);
    assign ce_burst   = w_run & (r_ph[3:0] == 4'hF);
    assign cpu_q      = w_run & (r_ph >= c_q_start) & (r_ph <= c_q_end);
    assign cpu_e      = w_run & r_ph[c_ph_w-1];
    assign cpu_e_rise = w_run & (r_ph == c_e_start);
    assign cpu_e_fall = w_run & (r_ph == c_ph_max);

`ifdef LOCK_LOSS_COUNT_EN
    logic [7:0] r_loss_cnt;

    // Only lock-driven exits from RUN count; rst has priority and clears
    always_ff @(posedge clk) begin
        if (rst) begin
            r_loss_cnt <= '0;
        end else if (w_run && !r_locked_s && (r_loss_cnt != 8'hFF)) begin
            r_loss_cnt <= r_loss_cnt + 8'd1;
        end
    end

    assign lock_loss_cnt = r_loss_cnt;
`endif

endmodule
`default_nettype wire

// File: doc/coco_clk_reset_gen.md
Name: coco_clk_reset_gen

Overview:
- Consumer end of the 57.272727 MHz PLL: turns the PLL `locked` status into a clean system reset.
- Derives every CoCo2 timing enable from the PLL output clock: 14.318 MHz pixel, 3.579545 MHz colorburst, and the 0.894886 MHz 6809 E/Q quadrature phases.
- Sits directly after the PLL instance in the top level; all core logic is single-clock on `clk` and qualified by these enables.

Parameters:
- LOCK_HOLD, 1024: cycles `locked` must stay stably high before `sys_reset` releases; legal range 2..65535.
- E_DIV, 64: `clk` cycles per CPU E period; must be a power of two, 16..256.

Ports:
- clk  in  1  PLL output clock, 57.272727 MHz.
- rst  in  1  synchronous, active-high reset.
- locked  in  1  PLL lock flag, asynchronous to `clk`.
- sys_reset  out  1  active-high core reset.
- ce_pix  out  1  1-cycle enable every 4 clks (14.318 MHz).
- ce_burst  out  1  1-cycle enable every 16 clks (3.579545 MHz).
- cpu_e  out  1  6809 E level.
- cpu_q  out  1  6809 Q level.
- cpu_e_rise  out  1  1-cycle pulse, first cycle E is high.
- cpu_e_fall  out  1  1-cycle pulse, last cycle E is high (data-capture strobe).

Behaviour:
- Clocking and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Synchronizer: `locked` passes through a 2-FF synchronizer to give `locked_s`; the synchronizer flops clear on `rst`.
- FSM states and transitions:
  - WAIT_LOCK: entered on `rst`. Go to HOLD (hold counter = 0) when `locked_s` = 1.
  - HOLD: increment the 16-bit hold counter each cycle.
    - If `locked_s` = 0, return to WAIT_LOCK.
    - When hold counter = LOCK_HOLD-1, go to RUN.
  - RUN: if `locked_s` = 0, go to WAIT_LOCK.
- sys_reset:
  - Equals (state != RUN). It is 1 during and after `rst`.
  - From `rst` low and `locked` rising, deasserts exactly LOCK_HOLD+3 clk edges later.
  - Reasserts exactly 3 edges after `locked` falls.
- Phase counter `ph`:
  - Width log2(E_DIV).
  - Held at 0 when not in RUN; increments by 1 each cycle in RUN and wraps at E_DIV-1 → 0.
  - The first RUN cycle has `ph` = 0.
- Enables: all combinational decodes of `ph`, and all forced to 0 outside RUN.
  - ce_pix = (ph[1:0] == 3).
  - ce_burst = (ph[3:0] == 15).
  - cpu_q = 1 for ph in [E_DIV/4, 3·E_DIV/4 - 1].
  - cpu_e = 1 for ph in [E_DIV/2, E_DIV-1].
  - cpu_e_rise = (ph == E_DIV/2).
  - cpu_e_fall = (ph == E_DIV-1).
- Quadrature: Q leads E by E_DIV/4 clks; both have a 50% duty cycle.
- Boundary conditions:
  - `locked` glitch of 1 clk: may or may not be caught by the synchronizer. If caught during HOLD, hold restarts from WAIT_LOCK; no partial enables are produced.
  - `rst` mid-RUN: next edge goes to WAIT_LOCK, `ph` = 0, all enables 0, `sys_reset` = 1.
  - `rst` and `locked` change in the same cycle: `rst` wins.
  - Lock loss mid-E-cycle: enables stop immediately when the FSM leaves RUN. Re-entry restarts at `ph` = 0, so the E period always restarts whole.

Optional Feature:
- Macro: LOCK_LOSS_COUNT_EN.
- When defined:
  - Adds output `lock_loss_cnt` [7:0].
  - The counter increments on every RUN→WAIT_LOCK transition caused by `locked_s` = 0, and saturates at 255.
  - Clears only on `rst`; a reset-driven exit from RUN does not count.
- When undefined: the port and the counter are absent; all other behaviour is identical.

Test Plan:
- LOCK_HOLD=16, `rst` pulse, then `locked`=1 at edge 0 → `sys_reset`=1 through edge 18, 0 after edge 19; `ph`=0 on the first RUN cycle.
- Steady RUN for 256 clks → `ce_pix` 64 pulses spaced 4; `ce_burst` 16 pulses spaced 16; `cpu_e` high for ph 32..63; `cpu_q` high for ph 16..47; `cpu_e_rise` at ph 32; `cpu_e_fall` at ph 63; exactly 4 of each.
- In RUN at ph=40, drop `locked` → `sys_reset`=1 and all enables 0 from edge 3. Restore `locked` → RUN after a further LOCK_HOLD+3 edges, with `cpu_e`=0 for the first 32 RUN cycles.
- `locked` drops for 5 clks at hold count 10 → FSM returns to WAIT_LOCK; `sys_reset` stays 1 continuously; the full LOCK_HOLD is re-counted.
- Assert `rst` during RUN with `locked`=1 → `sys_reset`=1 next cycle; release deasserts it LOCK_HOLD+3 edges after `rst` falls.
- LOCK_LOSS_COUNT_EN defined: 3 lock drops from RUN and 1 drop in HOLD → `lock_loss_cnt`=3. Then 300 drops → 255. `rst` → 0.
